// File: rtl/vc_req_pkg.sv
// rtl/vc_req_pkg.sv - shared state encoding and counter sizing for vc_request_gen
package vc_req_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Bits needed to hold a flit count from 0 up to max_flits inclusive.
    function automatic int cnt_width(input int max_flits);
        return (max_flits < 1) ? 1 : $clog2(max_flits + 1);
    endfunction

endpackage

// File: rtl/vc_request_gen_if.sv
// rtl/vc_request_gen_if.sv - VC buffer / arbiter / output-port handshake bundle
interface vc_request_gen_if #(
    parameter int ARBITER_WIDTH = 4
);
    logic [ARBITER_WIDTH-1:0] vc_not_empty;
    logic [ARBITER_WIDTH-1:0] vc_head_is_tail;
    logic                     downstream_ready;
    logic [ARBITER_WIDTH-1:0] request;
    logic [ARBITER_WIDTH-1:0] grant;
    logic                     any_grant;
    logic [ARBITER_WIDTH-1:0] vc_dequeue;
    logic                     locked;
    logic                     protocol_error;

    // Request generator side
    modport master (
        input  vc_not_empty, vc_head_is_tail, downstream_ready, grant, any_grant,
        output request, vc_dequeue, locked, protocol_error
    );

    // Environment side: VC buffers, arbiter and output port
    modport slave (
        output vc_not_empty, vc_head_is_tail, downstream_ready, grant, any_grant,
        input  request, vc_dequeue, locked, protocol_error
    );
endinterface

// File: rtl/one_hot_check.sv
// rtl/one_hot_check.sv - flags a vector with exactly one bit set
module one_hot_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] vec,
    output logic             is_one_hot
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Non-zero and clearing the lowest set bit leaves nothing behind.
    assign is_one_hot = (vec != '0) && ((vec & (vec - ONE)) == '0);
endmodule

// File: rtl/vc_request_gen.sv
// rtl/vc_request_gen.sv - wormhole request generator for a one-hot VC arbiter (optional checks: VC_REQ_ERR_CHECK_EN)
import vc_req_pkg::*;

module vc_request_gen #(
    parameter int ARBITER_WIDTH = 4,
    parameter int MAX_PKT_FLITS = 16
) (
    input logic               clk,
    input logic               reset,
    vc_request_gen_if.master  vif
);
    localparam int W = ARBITER_WIDTH;

    state_e         state_q, state_d;
    logic [W-1:0]   lock_vc_q, lock_vc_d;
    logic [W-1:0]   request_c;
    logic [W-1:0]   deq_c;
    logic           grant_one_hot;
    logic           grant_ok;
    logic           pop_ready;
    logic           pkt_overflow;

    one_hot_check #(.WIDTH(W)) u_grant_check (
        .vec        (vif.grant),
        .is_one_hot (grant_one_hot)
    );

    // Only arbitrate between packets; a locked packet must not move the arbiter pointer.
    assign request_c = (state_q == ST_IDLE) ?
                       (vif.vc_not_empty & {W{vif.downstream_ready}}) : '0;

    // A grant is honoured only if it is one-hot and lands on a VC we actually requested.
    assign grant_ok  = (state_q == ST_IDLE) && vif.any_grant && grant_one_hot &&
                       ((vif.grant & request_c) == vif.grant);

    // The owning VC has a flit and the output has credit.
    assign pop_ready = (state_q == ST_LOCKED) && (|(lock_vc_q & vif.vc_not_empty)) &&
                       vif.downstream_ready;

    // Next-state, lock owner and pop strobe.
    always_comb begin
        state_d   = state_q;
        lock_vc_d = lock_vc_q;
        deq_c     = '0;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    deq_c = vif.grant;
                    if ((vif.grant & vif.vc_head_is_tail) == '0) begin
                        state_d   = ST_LOCKED;
                        lock_vc_d = vif.grant;
                    end
                end
            end
            ST_LOCKED: begin
                if (pop_ready) begin
                    if (pkt_overflow) begin
                        state_d   = ST_IDLE;
                        lock_vc_d = '0;
                    end else begin
                        deq_c = lock_vc_q;
                        if (|(lock_vc_q & vif.vc_head_is_tail)) begin
                            state_d   = ST_IDLE;
                            lock_vc_d = '0;
                        end
                    end
                end
            end
        endcase
    end

    // State and lock owner registers; reset abandons any packet in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            lock_vc_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_vc_q <= lock_vc_d;
        end
    end

    assign vif.request    = reset ? request_c : '0;
    assign vif.vc_dequeue = reset ? deq_c : '0;
    assign vif.locked     = (state_q == ST_LOCKED);

`ifdef VC_REQ_ERR_CHECK_EN
    localparam int CNT_W = cnt_width(MAX_PKT_FLITS);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             grant_bad;

    assign pkt_overflow = (cnt_q == CNT_W'(MAX_PKT_FLITS));
    assign grant_bad    = vif.any_grant && !grant_ok;

    // Flits of the current packet popped so far (the granting pop counts as one).
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q | grant_bad | (pop_ready & pkt_overflow);
        if (state_d == ST_IDLE) begin
            cnt_d = '0;
        end else if (state_q == ST_IDLE) begin
            cnt_d = CNT_W'(1);
        end else if (pop_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Packet length counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign vif.protocol_error = err_q;
`else
    if (MAX_PKT_FLITS < 1) begin : g_bad_max_pkt_flits
        $error("MAX_PKT_FLITS must be at least 1");
    end

    assign pkt_overflow       = 1'b0;
    assign vif.protocol_error = 1'b0;
`endif

endmodule
